// File: rtl/floattoint.sv
// ---------------------------------------------------------------------------
// floattoint
//
// Purpose:
//    Converts an IEEE-754 single-precision operand into a signed
//    two's-complement integer of INT_WIDTH bits. This is the inverse of the
//    synth's int-to-float converter. It returns float-domain results
//    (oscillator and envelope math) to the sample bus.
//
//    The conversion is multi-cycle and shifts the mantissa one bit per clock.
//    Holding reset high captures a new operand. The conversion then runs once
//    reset goes low, and done flags the final result.
//
// Ports:
//    clk      input   1          system clock, rising edge
//    reset    input   1          synchronous active-high; captures floatin
//                                and arms a conversion
//    floatin  input   32         IEEE-754 single operand, sampled while reset
//                                is high
//    intout   output  INT_WIDTH  signed result, valid while done is high
//    done     output  1          registered completion flag, held until the
//                                next reset
//
// Parameters:
//    INT_WIDTH  output integer width (8..24), default 16
//
// Configuration macro:
//    FLOATTOINT_ROUND_NEAREST_EN  when defined, the result is rounded to
//                                 nearest-even using guard/sticky tracking.
//                                 When undefined, the result is truncated
//                                 toward zero, like a C cast.
// ---------------------------------------------------------------------------
module floattoint #(
   parameter int INT_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [31:0]                 floatin,
   output logic signed [INT_WIDTH-1:0] intout,
   output logic                        done
);

   typedef enum logic [1:0] {
      CLASSIFY,
      SHIFT,
      NEGATE,
      DONE
   } state_t;

   // Biased exponent at or above which the magnitude cannot fit:
   // e >= INT_WIDTH-1.
   localparam logic [8:0] SAT_EXP = 9'(127 + INT_WIDTH - 1);

   localparam logic [INT_WIDTH-1:0] SAT_POS = {1'b0, {(INT_WIDTH-1){1'b1}}};
   localparam logic [INT_WIDTH-1:0] SAT_NEG = {1'b1, {(INT_WIDTH-1){1'b0}}};

`ifdef FLOATTOINT_ROUND_NEAREST_EN
   localparam logic [24:0] MAX_POS_MAG = 25'((1 << (INT_WIDTH-1)) - 1);
   localparam logic [24:0] MAX_NEG_MAG = 25'(1 << (INT_WIDTH-1));
`endif

   state_t                  state_q, state_d;
   logic [31:0]             operand_q;
   logic [23:0]             mag_q, mag_d;
   logic [4:0]              k_q, k_d;
   logic [INT_WIDTH-1:0]    intout_q, intout_d;
   logic                    done_q, done_d;
`ifdef FLOATTOINT_ROUND_NEAREST_EN
   logic                    guard_q, guard_d;
   logic                    sticky_q, sticky_d;
   logic                    roundUp;
   logic [24:0]             rounded;
`endif

   logic                    sign;
   logic [7:0]              expField;
   logic [22:0]             frac;
   logic                    isNan;
   logic                    isInf;
   logic                    isSat;
   logic                    isZero;

   // Field decode of the captured operand. The "zero" class covers true zero,
   // denormals and every magnitude that truncates (or rounds) to 0 without
   // shifting. In rounding mode, e = -1 still has to go through the shifter,
   // because values in [0.5, 1) may round up to 1.
   assign sign     = operand_q[31];
   assign expField = operand_q[30:23];
   assign frac     = operand_q[22:0];
   assign isNan    = (expField == 8'hFF) && (frac != 23'd0);
   assign isInf    = (expField == 8'hFF) && (frac == 23'd0);
   assign isSat    = ({1'b0, expField} >= SAT_EXP);
`ifdef FLOATTOINT_ROUND_NEAREST_EN
   assign isZero   = (expField < 8'd126);
`else
   assign isZero   = (expField < 8'd127);
`endif

   assign intout = intout_q;
   assign done   = done_q;

   // Next-state and datapath logic. CLASSIFY resolves every special case in
   // one edge. Otherwise it loads the mantissa and the shift count
   // k = 23 - e = 150 - E. SHIFT walks the mantissa right one bit per edge
   // and leaves on the edge where k reaches zero. NEGATE applies the sign
   // (and, when enabled, the rounding increment) and raises done.
   always_comb begin
      state_d  = state_q;
      mag_d    = mag_q;
      k_d      = k_q;
      intout_d = intout_q;
      done_d   = done_q;
`ifdef FLOATTOINT_ROUND_NEAREST_EN
      guard_d  = guard_q;
      sticky_d = sticky_q;
      roundUp  = 1'b0;
      rounded  = 25'd0;
`endif
      case (state_q)
         CLASSIFY: begin
            if (isNan) begin
               intout_d = '0;
               done_d   = 1'b1;
               state_d  = DONE;
            end else if (isInf || isSat) begin
               intout_d = sign ? SAT_NEG : SAT_POS;
               done_d   = 1'b1;
               state_d  = DONE;
            end else if (isZero) begin
               intout_d = '0;
               done_d   = 1'b1;
               state_d  = DONE;
            end else begin
               mag_d    = {1'b1, frac};
               k_d      = 5'(8'd150 - expField);
`ifdef FLOATTOINT_ROUND_NEAREST_EN
               guard_d  = 1'b0;
               sticky_d = 1'b0;
`endif
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            mag_d = mag_q >> 1;
            k_d   = k_q - 5'd1;
`ifdef FLOATTOINT_ROUND_NEAREST_EN
            guard_d  = mag_q[0];
            sticky_d = sticky_q | guard_q;
`endif
            if (k_q == 5'd1) begin
               state_d = NEGATE;
            end
         end
         NEGATE: begin
`ifdef FLOATTOINT_ROUND_NEAREST_EN
            roundUp = guard_q & (sticky_q | mag_q[0]);
            rounded = {1'b0, mag_q} + {24'd0, roundUp};
            if (!sign && (rounded > MAX_POS_MAG)) begin
               intout_d = SAT_POS;
            end else if (sign && (rounded > MAX_NEG_MAG)) begin
               intout_d = SAT_NEG;
            end else begin
               intout_d = sign ? -rounded[INT_WIDTH-1:0] : rounded[INT_WIDTH-1:0];
            end
`else
            intout_d = sign ? -mag_q[INT_WIDTH-1:0] : mag_q[INT_WIDTH-1:0];
`endif
            done_d  = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            state_d = DONE;
         end
         default: begin
            state_d = DONE;
         end
      endcase
   end

   // State register. Reset has priority: it clears the visible outputs,
   // re-arms CLASSIFY and captures the operand. A reset during a conversion
   // therefore simply aborts it. The operand register holds its value
   // outside reset, so later changes on floatin are ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= CLASSIFY;
         operand_q <= floatin;
         mag_q     <= '0;
         k_q       <= '0;
         intout_q  <= '0;
         done_q    <= 1'b0;
`ifdef FLOATTOINT_ROUND_NEAREST_EN
         guard_q   <= 1'b0;
         sticky_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         mag_q     <= mag_d;
         k_q       <= k_d;
         intout_q  <= intout_d;
         done_q    <= done_d;
`ifdef FLOATTOINT_ROUND_NEAREST_EN
         guard_q   <= guard_d;
         sticky_q  <= sticky_d;
`endif
      end
   end

endmodule

// File: tb/tb_floattoint.sv
// ---------------------------------------------------------------------------
// tb_floattoint
//
// Directed testbench for floattoint with INT_WIDTH = 16. Each scenario task
// loads an operand through reset and counts edges after reset falls until
// done rises. It then compares the result and the latency against
// hand-computed values. Expectations follow FLOATTOINT_ROUND_NEAREST_EN
// when that macro is defined.
// ---------------------------------------------------------------------------
module tb_floattoint;

   logic               clk;
   logic               reset;
   logic [31:0]        floatin;
   logic signed [15:0] intout;
   logic               done;

   int checks;
   int errors;

   floattoint #(.INT_WIDTH(16)) dut (
      .clk     (clk),
      .reset   (reset),
      .floatin (floatin),
      .intout  (intout),
      .done    (done)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Holds reset high with the operand for two edges, then drops it on a
   // falling edge. The next rising edge is edge 1.
   task automatic applyStimulus(input logic [31:0] f);
      @(negedge clk);
      reset   = 1'b1;
      floatin = f;
      @(negedge clk);
      @(negedge clk);
      reset   = 1'b0;
   endtask

   // Counts rising edges (sampled 1 ns after each edge) until done is seen.
   // The count starts from startEdge. A missing done within the budget
   // returns -1.
   task automatic waitDone(input int startEdge, output int edges);
      edges = -1;
      for (int n = startEdge + 1; n <= 60; n++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            edges = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset   = 1'b1;
      floatin = 32'h46fffe00;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_done: got %b expected 0", done);
      end
      checks++;
      if (intout !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL reset_intout: got %h expected 0000", intout);
      end
   endtask

   task automatic test_normal();
      logic [31:0] vin  [4] = '{32'h46fffe00, 32'h41700000, 32'hc1d80000, 32'h42f6e979};
      logic [15:0] vexp [4] = '{16'h7fff,     16'h000f,     16'hffe5,     16'h007b};
      int          vlat [4] = '{11,           22,           21,           19};
      int          edges;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(vin[i]);
         waitDone(0, edges);
         checks++;
         if (edges !== vlat[i]) begin
            errors++;
            $display("[TB] FAIL normal_latency[%h]: got %0d expected %0d", vin[i], edges, vlat[i]);
         end
         checks++;
         if (intout !== vexp[i]) begin
            errors++;
            $display("[TB] FAIL normal_value[%h]: got %h expected %h", vin[i], intout, vexp[i]);
         end
      end
   endtask

   task automatic test_specials();
      logic [31:0] vin  [9] = '{32'hc7000000, 32'h00000000, 32'h80000000, 32'h00000001,
                                32'h7f800000, 32'hff800000, 32'h7fc00000, 32'h47800000,
                                32'hc7800000};
      logic [15:0] vexp [9] = '{16'h8000, 16'h0000, 16'h0000, 16'h0000,
                                16'h7fff, 16'h8000, 16'h0000, 16'h7fff,
                                16'h8000};
      int          edges;
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vin[i]);
         waitDone(0, edges);
         checks++;
         if (edges !== 1) begin
            errors++;
            $display("[TB] FAIL special_latency[%h]: got %0d expected 1", vin[i], edges);
         end
         checks++;
         if (intout !== vexp[i]) begin
            errors++;
            $display("[TB] FAIL special_value[%h]: got %h expected %h", vin[i], intout, vexp[i]);
         end
      end
   endtask

   task automatic test_rounding();
      logic [31:0] vin  [5] = '{32'h3fc00000, 32'h40200000, 32'hbf400000, 32'h3f000000, 32'h46ffff00};
`ifdef FLOATTOINT_ROUND_NEAREST_EN
      logic [15:0] vexp [5] = '{16'h0002, 16'h0002, 16'hffff, 16'h0000, 16'h7fff};
      int          vlat [5] = '{25,       24,       26,       26,       11};
`else
      logic [15:0] vexp [5] = '{16'h0001, 16'h0002, 16'h0000, 16'h0000, 16'h7fff};
      int          vlat [5] = '{25,       24,       1,        1,        11};
`endif
      int          edges;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(vin[i]);
         waitDone(0, edges);
         checks++;
         if (edges !== vlat[i]) begin
            errors++;
            $display("[TB] FAIL round_latency[%h]: got %0d expected %0d", vin[i], edges, vlat[i]);
         end
         checks++;
         if (intout !== vexp[i]) begin
            errors++;
            $display("[TB] FAIL round_value[%h]: got %h expected %h", vin[i], intout, vexp[i]);
         end
      end
   endtask

   task automatic test_abort();
      int edges;
      applyStimulus(32'h3f800000);
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset   = 1'b1;
      floatin = 32'hc1d80000;
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || intout !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL abort_clear: got done=%b intout=%h expected done=0 intout=0000", done, intout);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_early_done: got %b expected 0", done);
      end
      floatin = 32'h7f800000;
      waitDone(3, edges);
      checks++;
      if (edges !== 21) begin
         errors++;
         $display("[TB] FAIL abort_latency: got %0d expected 21", edges);
      end
      checks++;
      if (intout !== 16'hffe5) begin
         errors++;
         $display("[TB] FAIL abort_value: got %h expected ffe5", intout);
      end
   endtask

   task automatic test_hold();
      int edges;
      applyStimulus(32'h41700000);
      waitDone(0, edges);
      floatin = 32'h3f800000;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b1 || intout !== 16'h000f) begin
         errors++;
         $display("[TB] FAIL hold: got done=%b intout=%h expected done=1 intout=000f", done, intout);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || intout !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL reset_after_done: got done=%b intout=%h expected done=0 intout=0000", done, intout);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Scenario sequence.
   initial begin
      checks  = 0;
      errors  = 0;
      reset   = 1'b1;
      floatin = 32'h0;
      test_reset();
      test_normal();
      test_specials();
      test_rounding();
      test_abort();
      test_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
